mem_backend_ctrl: RTL and testbench

Memory-side controller between the direct-mapped cache's memory port and a single-port backing word array. Accepts one read or write request per cycle over a request/grant handshake. Posts writes into a small in-order write buffer that drains to the array in the background. Returns read data with a fixed array latency, or one cycle after acceptance when the read hits a buffered write.

---
 rtl/mem_backend_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mem_backend_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_backend_ctrl.sv
// mem_backend_ctrl: memory-side controller between the cache memory port and a
// single-port backing word array. Writes are posted into an in-order buffer that
// drains in the background; reads are forwarded from the buffer when they hit a
// buffered write, or otherwise fetched from the array with a fixed latency.
module mem_backend_ctrl #(
  parameter int ADDR_BITS  = 10,
  parameter int LATENCY    = 4,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_req,
  input  logic                          mem_wr_en,
  input  logic [31:0]                   mem_addr,
  input  logic [31:0]                   mem_wr_data,
  output logic                          mem_gnt,
  output logic [31:0]                   mem_read,
  output logic                          mem_rvalid,
  output logic                          busy,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

  localparam int PTR_W   = $clog2(WBUF_DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef logic [ADDR_BITS-1:0] idx_t;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_READ} state_e;

  // Array-side FSM
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_done, read_done;

  // Write buffer (circular, head = oldest entry)
  idx_t               wbuf_idx_q  [WBUF_DEPTH];
  logic [31:0]        wbuf_data_q [WBUF_DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               wbuf_full;

  // Outstanding read
  logic        rd_pending_q, rd_pending_d;
  logic        rd_hit_q, rd_hit_d;
  idx_t        rd_idx_q, rd_idx_d;
  logic [31:0] rd_fwd_q, rd_fwd_d;

  // Output registers
  logic [31:0] mem_read_q;
  logic        mem_rvalid_q;
  logic        busy_q, busy_d;

  // Backing array
  logic [31:0] array_q [2**ADDR_BITS];

  idx_t        req_idx;
  logic        accept_wr, accept_rd;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  assign req_idx = mem_addr[ADDR_BITS-1:0];

  // Upper address bits alias onto the same words and are deliberately ignored.
  if (ADDR_BITS < 32) begin : g_alias
    logic unused_upper_addr;
    assign unused_upper_addr = ^mem_addr[31:ADDR_BITS];
  end

  assign wbuf_full = (count_q == COUNT_W'(WBUF_DEPTH));
  // A pending read blocks everything so a later write can never overtake it.
  assign mem_gnt   = rst_n && !rd_pending_q && (mem_wr_en ? !wbuf_full : 1'b1);
  assign accept_wr = mem_req && mem_gnt && mem_wr_en;
  assign accept_rd = mem_req && mem_gnt && !mem_wr_en;

  // Forwarding search: scan oldest to youngest so the youngest match wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int j = 0; j < WBUF_DEPTH; j++) begin
      if ((COUNT_W'(j) < count_q) && (wbuf_idx_q[head_q + PTR_W'(j)] == req_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wbuf_data_q[head_q + PTR_W'(j)];
      end
    end
  end

  // Array FSM next state: read misses take priority, a started drain always completes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_done = 1'b0;
    read_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_pending_q && !rd_hit_q) begin
          state_d = ST_READ;
          cnt_d   = CNT_W'(LATENCY - 1);
        end else if (count_q != '0) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          drain_done = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          read_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Array FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Buffer pointers and occupancy: push on accepted write, pop when a drain finishes.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain_done) head_d = head_q + 1'b1;
    if (accept_wr)  tail_d = tail_q + 1'b1;
    if (accept_wr && !drain_done)      count_d = count_q + 1'b1;
    else if (!accept_wr && drain_done) count_d = count_q - 1'b1;
  end

  // Outstanding-read bookkeeping: capture hit/miss at acceptance, clear on delivery.
  always_comb begin
    rd_pending_d = rd_pending_q;
    rd_hit_d     = rd_hit_q;
    rd_idx_d     = rd_idx_q;
    rd_fwd_d     = rd_fwd_q;
    if (rd_pending_q && (rd_hit_q || read_done)) rd_pending_d = 1'b0;
    if (accept_rd) begin
      rd_pending_d = 1'b1;
      rd_hit_d     = fwd_hit;
      rd_idx_d     = req_idx;
      rd_fwd_d     = fwd_data;
    end
  end

  assign busy_d = (count_d != '0) || rd_pending_d;

  // Control registers for buffer, read tracking and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
      rd_hit_q     <= 1'b0;
      rd_idx_q     <= '0;
      rd_fwd_q     <= '0;
      mem_read_q   <= '0;
      mem_rvalid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      rd_pending_q <= rd_pending_d;
      rd_hit_q     <= rd_hit_d;
      rd_idx_q     <= rd_idx_d;
      rd_fwd_q     <= rd_fwd_d;
      busy_q       <= busy_d;
      mem_rvalid_q <= 1'b0;
      if (rd_pending_q && rd_hit_q) begin
        mem_read_q   <= rd_fwd_q;
        mem_rvalid_q <= 1'b1;
      end else if (read_done) begin
        mem_read_q   <= array_q[rd_idx_q];
        mem_rvalid_q <= 1'b1;
      end
    end
  end

  // Buffer entry storage, written at the tail on each accepted write.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; validity comes from the reset pointers and count, not from the contents.
    if (accept_wr) begin
      wbuf_idx_q[tail_q]  <= req_idx;
      wbuf_data_q[tail_q] <= mem_wr_data;
    end
  end

  // Backing array: the head entry lands here on the final drain edge.
  always_ff @(posedge clk) begin
    if (drain_done) array_q[wbuf_idx_q[head_q]] <= wbuf_data_q[head_q];
  end

  assign mem_read   = mem_read_q;
  assign mem_rvalid = mem_rvalid_q;
  assign busy       = busy_q;
  assign wbuf_count = count_q;

endmodule

// File: tb/tb_mem_backend_ctrl.sv
// Self-checking bench for mem_backend_ctrl: directed scenarios plus random
// traffic, all compared against a timestamp-based behavioural model.
module tb_mem_backend_ctrl;

  localparam int ADDR_BITS  = 10;
  localparam int LATENCY    = 4;
  localparam int WBUF_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic        mem_gnt;
  logic [31:0] mem_read;
  logic        mem_rvalid;
  logic        busy;
  logic [$clog2(WBUF_DEPTH):0] wbuf_count;

  mem_backend_ctrl #(
    .ADDR_BITS (ADDR_BITS),
    .LATENCY   (LATENCY),
    .WBUF_DEPTH(WBUF_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_gnt    (mem_gnt),
    .mem_read   (mem_read),
    .mem_rvalid (mem_rvalid),
    .busy       (busy),
    .wbuf_count (wbuf_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          data;
  } went_t;

  logic [31:0]          mdl_mem [2**ADDR_BITS];
  went_t                m_wq [$];
  bit                   m_rd_pend = 0;
  bit                   m_rd_hit = 0;
  logic [ADDR_BITS-1:0] m_rd_idx = '0;
  logic [31:0]          m_rd_fwd = '0;
  bit                   m_op_active = 0;
  bit                   m_op_drain = 0;
  int                   m_op_end = 0;
  int                   m_free_from = 0;
  int                   m_edge = 0;
  bit                   m_rvalid = 0;
  logic [31:0]          m_read = '0;
  bit                   m_obs_rvalid = 0;
  bit                   m_obs_busy = 0;

  // One clock edge of the model: the array runs one access at a time, each
  // occupying LATENCY edges after it starts; it can start again the edge after.
  task automatic model_edge(input bit req, input bit we, input logic [ADDR_BITS-1:0] idx,
                            input logic [31:0] data, input bit gnt);
    bit          do_pop;
    bit          found;
    logic [31:0] fdata;
    went_t       e;
    m_edge++;
    m_rvalid = 0;
    do_pop   = 0;
    if (m_op_active && m_op_end == m_edge) begin
      if (m_op_drain) begin
        mdl_mem[m_wq[0].idx] = m_wq[0].data;
        do_pop = 1;
      end else begin
        m_rvalid  = 1;
        m_read    = mdl_mem[m_rd_idx];
        m_rd_pend = 0;
      end
      m_op_active = 0;
      m_free_from = m_edge + 1;
    end else if (!m_op_active && m_edge >= m_free_from) begin
      if (m_rd_pend && !m_rd_hit) begin
        m_op_active = 1; m_op_drain = 0; m_op_end = m_edge + LATENCY;
      end else if (m_wq.size() != 0) begin
        m_op_active = 1; m_op_drain = 1; m_op_end = m_edge + LATENCY;
      end
    end
    if (m_rd_pend && m_rd_hit) begin
      m_rvalid  = 1;
      m_read    = m_rd_fwd;
      m_rd_pend = 0;
    end
    if (req && gnt && !we) begin
      found = 0;
      fdata = '0;
      foreach (m_wq[i]) if (m_wq[i].idx == idx) begin found = 1; fdata = m_wq[i].data; end
      m_rd_pend = 1;
      m_rd_hit  = found;
      m_rd_fwd  = fdata;
      m_rd_idx  = idx;
    end
    if (do_pop) void'(m_wq.pop_front());
    if (req && gnt && we) begin
      e.idx  = idx;
      e.data = data;
      m_wq.push_back(e);
    end
  endtask

  task automatic model_reset();
    m_wq.delete();
    m_rd_pend   = 0;
    m_rd_hit    = 0;
    m_op_active = 0;
    m_free_from = 0;
    m_rvalid    = 0;
    m_read      = '0;
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] data, output bit got_gnt);
    bit exp_gnt;
    @(negedge clk);
    mem_req     = req;
    mem_wr_en   = we;
    mem_addr    = addr;
    mem_wr_data = data;
    #1;
    exp_gnt = !m_rd_pend && (we ? (m_wq.size() < WBUF_DEPTH) : 1'b1);
    got_gnt = mem_gnt;
    check("gnt", 32'(mem_gnt), 32'(exp_gnt));
    model_edge(req, we, addr[ADDR_BITS-1:0], data, exp_gnt);
    @(posedge clk);
    #1;
    check("rvalid", 32'(mem_rvalid), 32'(m_rvalid));
    check("rdata", mem_read, m_read);
    check("count", 32'(wbuf_count), 32'(m_wq.size()));
    check("busy", 32'(busy), 32'(m_wq.size() != 0 || m_rd_pend));
    m_obs_rvalid = mem_rvalid;
    m_obs_busy   = busy;
  endtask

  task automatic idle();
    bit g;
    cycle(1'b0, 1'b0, 32'h0, 32'h0, g);
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] data,
                       output int stalls);
    bit g;
    g = 0;
    stalls = 0;
    while (!g && stalls < 30) begin
      cycle(1'b1, we, addr, data, g);
      if (!g) stalls++;
    end
    if (!g) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rvalid(output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (!m_obs_rvalid && n < 30);
    if (!m_obs_rvalid) check("rvalid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (m_obs_busy && n < 80);
    if (m_obs_busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_n     = 1'b0;
    mem_req   = 1'b1;
    mem_wr_en = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", 32'(mem_gnt), 32'd0);
    check("rst_rvalid", 32'(mem_rvalid), 32'd0);
    check("rst_rdata", mem_read, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(wbuf_count), 32'd0);
    repeat (cycles) @(negedge clk);
    check("rst_gnt_hold", 32'(mem_gnt), 32'd0);
    mem_req = 1'b0;
    rst_n   = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [ADDR_BITS-1:0] pool [8] = '{10'h279, 10'h281, 10'h010, 10'h020,
                                     10'h000, 10'h3FF, 10'h155, 10'h0AA};
  logic [31:0]          init_val [8];

  initial begin
    int          n;
    int          s;
    bit          g;
    logic [31:0] addr;
    logic [31:0] vals [5];
    int          sel [5];

    #1 rst_n = 1'b0;

    // 1. reset state, then preload the address pool
    apply_reset(3);
    for (int i = 0; i < 8; i++) begin
      init_val[i] = $urandom();
      addr = $urandom();
      addr[ADDR_BITS-1:0] = pool[i];
      issue(1'b1, addr, init_val[i], s);
    end
    wait_idle(n);

    // 1. basic write, drain and read miss
    issue(1'b1, 32'h1234_5679, 32'h0000_0003, s);
    wait_idle(n);
    check("t1_drain_edges", 32'(n), 32'(LATENCY + 1));
    issue(1'b0, 32'h1234_5679, 32'h0, s);
    wait_rvalid(n);
    check("t1_miss_lat", 32'(n), 32'(LATENCY + 1));
    check("t1_miss_data", mem_read, 32'h0000_0003);

    // 2. forwarding from the youngest buffered write
    wait_idle(n);
    issue(1'b1, 32'h1234_5681, 32'h0000_0005, s);
    issue(1'b1, 32'h1234_5681, 32'h0000_0006, s);
    issue(1'b0, 32'h1234_5681, 32'h0, s);
    wait_rvalid(n);
    check("t2_fwd_lat", 32'(n), 32'd1);
    check("t2_fwd_data", mem_read, 32'h0000_0006);

    // 3. buffer full: fifth write waits for the first pop
    wait_idle(n);
    sel = '{4, 5, 6, 7, 0};
    for (int i = 0; i < 5; i++) begin
      vals[i] = $urandom();
      addr = $urandom();
      addr[ADDR_BITS-1:0] = pool[sel[i]];
      issue(1'b1, addr, vals[i], s);
      if (i < 4) check("t3_no_stall", 32'(s), 32'd0);
      if (i == 3) check("t3_full_count", 32'(wbuf_count), 32'(WBUF_DEPTH));
      if (i == 4) check("t3_fifth_stalls", 32'(s), 32'(LATENCY - 2));
    end
    for (int i = 0; i < 5; i++) begin
      addr = $urandom();
      addr[ADDR_BITS-1:0] = pool[sel[i]];
      issue(1'b0, addr, 32'h0, s);
      wait_rvalid(n);
      check("t3_readback", mem_read, vals[i]);
    end

    // 4. read miss queued behind a drain; writes blocked meanwhile
    wait_idle(n);
    issue(1'b1, 32'h0000_0010, 32'hA0A0_0010, s);
    issue(1'b0, 32'h0000_0020, 32'h0, s);
    n = 0;
    do begin
      cycle(1'b1, 1'b1, 32'h0000_0030, 32'h3333_3333, g);
      check("t4_wr_blocked", 32'(g), 32'd0);
      n++;
    end while (!m_obs_rvalid && n < 30);
    check("t4_behind_drain_lat", 32'(n), 32'(2 * LATENCY + 1));
    check("t4_b_data", mem_read, init_val[3]);
    issue(1'b0, 32'h0000_0010, 32'h0, s);
    wait_rvalid(n);
    check("t4_a_in_array", mem_read, 32'hA0A0_0010);

    // 5. aliasing of upper address bits
    wait_idle(n);
    issue(1'b1, 32'hAB34_5681, 32'h0000_0002, s);
    wait_idle(n);
    issue(1'b0, 32'h1234_5681, 32'h0, s);
    wait_rvalid(n);
    check("t5_alias", mem_read, 32'h0000_0002);

    // 6. reset two cycles into a drain loses the write
    wait_idle(n);
    issue(1'b1, 32'h5500_0020, 32'hDEAD_BEEF, s);
    idle();
    idle();
    apply_reset(2);
    for (int i = 0; i < 6; i++) begin
      idle();
      check("t6_no_rvalid", 32'(mem_rvalid), 32'd0);
    end
    issue(1'b0, 32'h0000_0020, 32'h0, s);
    wait_rvalid(n);
    check("t6_old_value", mem_read, init_val[3]);

    // Random traffic against the model, with two asynchronous resets.
    for (int c = 0; c < 2500; c++) begin
      bit                   req;
      bit                   we;
      logic [31:0]          data;
      if (c == 800 || c == 1700) apply_reset(2);
      req  = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      addr = $urandom();
      addr[ADDR_BITS-1:0] = pool[$urandom_range(0, 7)];
      data = $urandom();
      cycle(req, we, addr, data, g);
    end
    wait_idle(n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
